bist_tap_ctrl: RTL and testbench

IEEE 1149.1-style TAP controller and instruction decoder that sequences the BIST engine from the JTAG pins. It runs the 16-state TAP FSM and holds the instruction register. It generates TLR, UPDATEDR, GETTEST_SELECT and RUNBIST_SELECT for the BIST block, shifts the 10-bit BSR test vector in, and captures the 16-bit BIST_STATUS word for readout on TDO.

---
 rtl/bist_tap_ctrl_if.sv | 28 ++
 rtl/bist_tap_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_bist_tap_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bist_tap_ctrl_if.sv
// JTAG pin and BIST-side signal bundle for the BIST TAP controller.
// The master side drives the JTAG inputs and status; the slave side is the TAP controller.
interface bist_tap_ctrl_if #(
    parameter int BSR_WIDTH    = 10,
    parameter int STATUS_WIDTH = 16
);
    logic                    TMS;
    logic                    TDI;
    logic                    TDO;
    logic                    TDO_EN;
    logic                    TLR;
    logic                    UPDATEDR;
    logic                    GETTEST_SELECT;
    logic                    RUNBIST_SELECT;
    logic [BSR_WIDTH-1:0]    BSR;
    logic [STATUS_WIDTH-1:0] BIST_STATUS;
    logic [3:0]              TAP_STATE;

    modport master (
        output TMS, TDI, BIST_STATUS,
        input  TDO, TDO_EN, TLR, UPDATEDR, GETTEST_SELECT, RUNBIST_SELECT, BSR, TAP_STATE
    );

    modport slave (
        input  TMS, TDI, BIST_STATUS,
        output TDO, TDO_EN, TLR, UPDATEDR, GETTEST_SELECT, RUNBIST_SELECT, BSR, TAP_STATE
    );
endinterface

// File: rtl/bist_tap_ctrl.sv
// IEEE 1149.1-style TAP controller with instruction decode that sequences the BIST engine:
// loads the GETTEST vector onto BSR, raises the run/select strobes and reads back BIST_STATUS.
module bist_tap_ctrl #(
    parameter int          IR_WIDTH     = 4,
    parameter int          BSR_WIDTH    = 10,
    parameter int          STATUS_WIDTH = 16,
    parameter logic [31:0] IDCODE_VAL   = 32'h1BD0_0001
) (
    input  logic             TCK,
    input  logic             TRST,
    bist_tap_ctrl_if.slave   jtag
);

    typedef logic [IR_WIDTH-1:0] ir_t;

    localparam ir_t OP_IDCODE  = ir_t'(4'h1);
    localparam ir_t OP_GETTEST = ir_t'(4'h2);
    localparam ir_t OP_RUNBIST = ir_t'(4'h3);
    localparam ir_t OP_STATUS  = ir_t'(4'h4);
    localparam ir_t IR_CAPTURE = ir_t'(4'b0101);

    typedef enum logic [3:0] {
        EXIT2_DR         = 4'h0,
        EXIT1_DR         = 4'h1,
        SHIFT_DR         = 4'h2,
        PAUSE_DR         = 4'h3,
        SELECT_IR        = 4'h4,
        UPDATE_DR        = 4'h5,
        CAPTURE_DR       = 4'h6,
        SELECT_DR        = 4'h7,
        EXIT2_IR         = 4'h8,
        EXIT1_IR         = 4'h9,
        SHIFT_IR         = 4'hA,
        PAUSE_IR         = 4'hB,
        RUN_TEST_IDLE    = 4'hC,
        UPDATE_IR        = 4'hD,
        CAPTURE_IR       = 4'hE,
        TEST_LOGIC_RESET = 4'hF
    } tap_state_e;

    // RUNBIST and all unknown opcodes use the 1-bit bypass register.
    typedef enum logic [1:0] {
        DR_BYPASS,
        DR_IDCODE,
        DR_GETTEST,
        DR_STATUS
    } dr_sel_e;

    tap_state_e state, state_nxt;
    logic       in_tlr, cap_dr, sh_dr, upd_dr, cap_ir, sh_ir, upd_ir;

    ir_t        ir_shift, ir_active;
    dr_sel_e    dr_sel;
    logic       gettest_sel, runbist_sel;

    logic                    bypass_reg;
    logic [31:0]             idcode_reg;
    logic [BSR_WIDTH-1:0]    gettest_reg;
    logic [STATUS_WIDTH-1:0] status_reg;

    logic dr_lsb, tdo_nxt;
    logic tdo_q, tdo_en_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            state <= TEST_LOGIC_RESET;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        state_nxt = state;
        in_tlr    = 1'b0;
        cap_dr    = 1'b0;
        sh_dr     = 1'b0;
        upd_dr    = 1'b0;
        cap_ir    = 1'b0;
        sh_ir     = 1'b0;
        upd_ir    = 1'b0;
        case (state)
            TEST_LOGIC_RESET: begin
                in_tlr    = 1'b1;
                state_nxt = jtag.TMS ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
            end
            RUN_TEST_IDLE: state_nxt = jtag.TMS ? SELECT_DR : RUN_TEST_IDLE;
            SELECT_DR:     state_nxt = jtag.TMS ? SELECT_IR : CAPTURE_DR;
            CAPTURE_DR: begin
                cap_dr    = 1'b1;
                state_nxt = jtag.TMS ? EXIT1_DR : SHIFT_DR;
            end
            SHIFT_DR: begin
                sh_dr     = 1'b1;
                state_nxt = jtag.TMS ? EXIT1_DR : SHIFT_DR;
            end
            EXIT1_DR:  state_nxt = jtag.TMS ? UPDATE_DR : PAUSE_DR;
            PAUSE_DR:  state_nxt = jtag.TMS ? EXIT2_DR  : PAUSE_DR;
            EXIT2_DR:  state_nxt = jtag.TMS ? UPDATE_DR : SHIFT_DR;
            UPDATE_DR: begin
                upd_dr    = 1'b1;
                state_nxt = jtag.TMS ? SELECT_DR : RUN_TEST_IDLE;
            end
            SELECT_IR: state_nxt = jtag.TMS ? TEST_LOGIC_RESET : CAPTURE_IR;
            CAPTURE_IR: begin
                cap_ir    = 1'b1;
                state_nxt = jtag.TMS ? EXIT1_IR : SHIFT_IR;
            end
            SHIFT_IR: begin
                sh_ir     = 1'b1;
                state_nxt = jtag.TMS ? EXIT1_IR : SHIFT_IR;
            end
            EXIT1_IR:  state_nxt = jtag.TMS ? UPDATE_IR : PAUSE_IR;
            PAUSE_IR:  state_nxt = jtag.TMS ? EXIT2_IR  : PAUSE_IR;
            EXIT2_IR:  state_nxt = jtag.TMS ? UPDATE_IR : SHIFT_IR;
            UPDATE_IR: begin
                upd_ir    = 1'b1;
                state_nxt = jtag.TMS ? SELECT_DR : RUN_TEST_IDLE;
            end
            default:   state_nxt = TEST_LOGIC_RESET;
        endcase
    end

    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            ir_shift  <= '0;
            ir_active <= OP_IDCODE;
        end else begin
            if (in_tlr) begin
                ir_active <= OP_IDCODE;
            end else if (upd_ir) begin
                ir_active <= ir_shift;
            end
            if (cap_ir) begin
                ir_shift <= IR_CAPTURE;
            end else if (sh_ir) begin
                ir_shift <= {jtag.TDI, ir_shift[IR_WIDTH-1:1]};
            end
        end
    end

    always_comb begin
        dr_sel      = DR_BYPASS;
        gettest_sel = 1'b0;
        runbist_sel = 1'b0;
        case (ir_active)
            OP_IDCODE:  dr_sel = DR_IDCODE;
            OP_GETTEST: begin
                dr_sel      = DR_GETTEST;
                gettest_sel = 1'b1;
            end
            OP_RUNBIST: runbist_sel = 1'b1;
            OP_STATUS:  dr_sel = DR_STATUS;
            default:    dr_sel = DR_BYPASS;
        endcase
    end

    // GETTEST has no capture value: it keeps the last vector so BIST can reuse it.
    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            bypass_reg  <= 1'b0;
            idcode_reg  <= '0;
            gettest_reg <= '0;
            status_reg  <= '0;
        end else if (cap_dr) begin
            case (dr_sel)
                DR_BYPASS: bypass_reg <= 1'b0;
                DR_IDCODE: idcode_reg <= IDCODE_VAL;
                DR_STATUS: status_reg <= jtag.BIST_STATUS;
                default:   ;
            endcase
        end else if (sh_dr) begin
            case (dr_sel)
                DR_BYPASS:  bypass_reg  <= jtag.TDI;
                DR_IDCODE:  idcode_reg  <= {jtag.TDI, idcode_reg[31:1]};
                DR_GETTEST: gettest_reg <= {jtag.TDI, gettest_reg[BSR_WIDTH-1:1]};
                DR_STATUS:  status_reg  <= {jtag.TDI, status_reg[STATUS_WIDTH-1:1]};
                default:    ;
            endcase
        end
    end

    always_comb begin
        dr_lsb = bypass_reg;
        case (dr_sel)
            DR_IDCODE:  dr_lsb = idcode_reg[0];
            DR_GETTEST: dr_lsb = gettest_reg[0];
            DR_STATUS:  dr_lsb = status_reg[0];
            default:    dr_lsb = bypass_reg;
        endcase
    end

    assign tdo_nxt = sh_ir ? ir_shift[0] : (sh_dr ? dr_lsb : 1'b0);

    // TDO changes on the falling edge so the next rising edge samples a settled bit.
    always_ff @(negedge TCK or negedge TRST) begin
        if (!TRST) begin
            tdo_q    <= 1'b0;
            tdo_en_q <= 1'b0;
        end else begin
            tdo_q    <= tdo_nxt;
            tdo_en_q <= sh_ir | sh_dr;
        end
    end

    assign jtag.TDO            = tdo_q;
    assign jtag.TDO_EN         = tdo_en_q;
    assign jtag.TLR            = in_tlr;
    assign jtag.UPDATEDR       = upd_dr;
    assign jtag.GETTEST_SELECT = gettest_sel;
    assign jtag.RUNBIST_SELECT = runbist_sel;
    assign jtag.BSR            = gettest_reg;
    assign jtag.TAP_STATE      = state;

endmodule

// File: tb/tb_bist_tap_ctrl.sv
// Self-checking bench for bist_tap_ctrl: directed JTAG scans plus randomized TMS/TDI traffic
// compared every cycle against a table-driven TAP reference model.
module tb_bist_tap_ctrl;

    localparam logic [31:0] IDCODE_VAL = 32'h1BD0_0001;

    // Next-state tables indexed by state code: NEXT0 for TMS=0, NEXT1 for TMS=1.
    localparam logic [3:0] NEXT0 [16] = '{4'h2, 4'h3, 4'h2, 4'h3, 4'hE, 4'hC, 4'h2, 4'h6,
                                          4'hA, 4'hB, 4'hA, 4'hB, 4'hC, 4'hC, 4'hA, 4'hC};
    localparam logic [3:0] NEXT1 [16] = '{4'h5, 4'h5, 4'h1, 4'h0, 4'hF, 4'h7, 4'h1, 4'h4,
                                          4'hD, 4'hD, 4'h9, 4'h8, 4'h7, 4'h7, 4'h9, 4'hF};

    logic TCK = 1'b0;
    logic TRST;

    bist_tap_ctrl_if #(.BSR_WIDTH(10), .STATUS_WIDTH(16)) tap ();

    bist_tap_ctrl #(
        .IR_WIDTH    (4),
        .BSR_WIDTH   (10),
        .STATUS_WIDTH(16),
        .IDCODE_VAL  (IDCODE_VAL)
    ) dut (
        .TCK (TCK),
        .TRST(TRST),
        .jtag(tap)
    );

    always #5 TCK = ~TCK;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [3:0]  m_state;
    logic [3:0]  m_ir_sh, m_ir_act;
    logic        m_byp;
    logic [31:0] m_id;
    logic [9:0]  m_gt;
    logic [15:0] m_st;
    logic        m_tdo, m_tdo_en;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [31:0] shift_in(input logic [31:0] v, input int len, input logic tdi);
        return (v >> 1) | (32'(tdi) << (len - 1));
    endfunction

    function automatic logic dr_lsb_model();
        case (m_ir_act)
            4'h1:    return m_id[0];
            4'h2:    return m_gt[0];
            4'h4:    return m_st[0];
            default: return m_byp;
        endcase
    endfunction

    task automatic model_reset();
        m_state  = 4'hF;
        m_ir_sh  = 4'h0;
        m_ir_act = 4'h1;
        m_byp    = 1'b0;
        m_id     = '0;
        m_gt     = '0;
        m_st     = '0;
        m_tdo    = 1'b0;
        m_tdo_en = 1'b0;
    endtask

    task automatic model_rise(input logic tms, input logic tdi);
        case (m_state)
            4'hF: m_ir_act = 4'h1;
            4'hE: m_ir_sh  = 4'b0101;
            4'hA: m_ir_sh  = 4'(shift_in(32'(m_ir_sh), 4, tdi));
            4'hD: m_ir_act = m_ir_sh;
            4'h6: begin
                if (m_ir_act == 4'h1)      m_id = IDCODE_VAL;
                else if (m_ir_act == 4'h4) m_st = tap.BIST_STATUS;
                else if (m_ir_act != 4'h2) m_byp = 1'b0;
            end
            4'h2: begin
                if (m_ir_act == 4'h1)      m_id = shift_in(m_id, 32, tdi);
                else if (m_ir_act == 4'h2) m_gt = 10'(shift_in(32'(m_gt), 10, tdi));
                else if (m_ir_act == 4'h4) m_st = 16'(shift_in(32'(m_st), 16, tdi));
                else                       m_byp = tdi;
            end
            default: ;
        endcase
        m_state = tms ? NEXT1[m_state] : NEXT0[m_state];
    endtask

    task automatic model_fall();
        m_tdo_en = (m_state == 4'hA) || (m_state == 4'h2);
        if (m_state == 4'hA)      m_tdo = m_ir_sh[0];
        else if (m_state == 4'h2) m_tdo = dr_lsb_model();
        else                      m_tdo = 1'b0;
    endtask

    // One TCK cycle: drive at negedge+1, check registered outputs after both edges.
    task automatic step(input logic tms, input logic tdi, output logic tdo_seen);
        tap.TMS = tms;
        tap.TDI = tdi;
        @(posedge TCK);
        model_rise(tms, tdi);
        #1;
        check("tap_state", 32'(tap.TAP_STATE), 32'(m_state));
        check("tlr", 32'(tap.TLR), 32'(m_state == 4'hF));
        check("updatedr", 32'(tap.UPDATEDR), 32'(m_state == 4'h5));
        check("gettest_select", 32'(tap.GETTEST_SELECT), 32'(m_ir_act == 4'h2));
        check("runbist_select", 32'(tap.RUNBIST_SELECT), 32'(m_ir_act == 4'h3));
        check("bsr", 32'(tap.BSR), 32'(m_gt));
        @(negedge TCK);
        model_fall();
        #1;
        check("tdo", 32'(tap.TDO), 32'(m_tdo));
        check("tdo_en", 32'(tap.TDO_EN), 32'(m_tdo_en));
        tdo_seen = tap.TDO;
    endtask

    task automatic go_tlr();
        logic d;
        for (int i = 0; i < 5; i++) step(1'b1, 1'($urandom), d);
    endtask

    task automatic goto_rti();
        logic d;
        go_tlr();
        step(1'b0, 1'b0, d);
    endtask

    // From Run-Test/Idle: scan an IR value, return the bits shifted out, end in Run-Test/Idle.
    task automatic load_ir(input logic [3:0] v, output logic [3:0] cap);
        logic d;
        step(1'b1, 1'b0, d);
        step(1'b1, 1'b0, d);
        step(1'b0, 1'b0, d);
        step(1'b0, 1'b0, cap[0]);
        for (int i = 0; i < 4; i++) begin
            step(i == 3, v[i], d);
            if (i < 3) cap[i+1] = d;
        end
        step(1'b1, 1'b0, d);
        step(1'b0, 1'b0, d);
    endtask

    // From Run-Test/Idle: capture, shift n bits LSB-first, update, back to Run-Test/Idle.
    task automatic dr_scan(input int n, input logic [63:0] din, output logic [63:0] dout);
        logic d;
        dout = '0;
        step(1'b1, 1'b0, d);
        step(1'b0, 1'b0, d);
        step(1'b0, 1'b0, d);
        dout[0] = d;
        for (int i = 0; i < n; i++) begin
            step(i == n - 1, din[i], d);
            if (i < n - 1) dout[i+1] = d;
        end
        step(1'b1, 1'b0, d);
        step(1'b0, 1'b0, d);
    endtask

    task automatic dr_scan_paused();
        logic d;
        step(1'b1, 1'b0, d);
        step(1'b0, 1'b0, d);
        step(1'b0, 1'b0, d);
        repeat ($urandom_range(1, 6)) step(1'b0, 1'($urandom), d);
        step(1'b1, 1'($urandom), d);
        repeat ($urandom_range(1, 5)) step(1'b0, 1'($urandom), d);
        step(1'b1, 1'($urandom), d);
        step(1'b0, 1'($urandom), d);
        repeat ($urandom_range(1, 6)) step(1'b0, 1'($urandom), d);
        step(1'b1, 1'($urandom), d);
        step(1'b1, 1'b0, d);
        step(1'b0, 1'b0, d);
    endtask

    // Asynchronous reset pulse placed between clock edges, released after the next falling edge.
    task automatic trst_pulse(input string tag);
        #1;
        TRST = 1'b0;
        model_reset();
        #1;
        check({tag, "_state"}, 32'(tap.TAP_STATE), 32'hF);
        check({tag, "_tlr"}, 32'(tap.TLR), 32'h1);
        check({tag, "_bsr"}, 32'(tap.BSR), 32'h0);
        check({tag, "_tdo_en"}, 32'(tap.TDO_EN), 32'h0);
        check({tag, "_tdo"}, 32'(tap.TDO), 32'h0);
        check({tag, "_gettest_sel"}, 32'(tap.GETTEST_SELECT), 32'h0);
        check({tag, "_updatedr"}, 32'(tap.UPDATEDR), 32'h0);
        @(negedge TCK);
        #1;
        TRST = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        d;
        logic [3:0]  cap;
        logic [63:0] din, dout;
        logic [3:0]  ir_pick [6];
        bit          reached;

        TRST            = 1'b0;
        tap.TMS         = 1'b1;
        tap.TDI         = 1'b0;
        tap.BIST_STATUS = '0;
        model_reset();
        repeat (2) @(negedge TCK);
        #1;
        check("rst_state", 32'(tap.TAP_STATE), 32'hF);
        check("rst_tlr", 32'(tap.TLR), 32'h1);
        check("rst_updatedr", 32'(tap.UPDATEDR), 32'h0);
        check("rst_gettest_sel", 32'(tap.GETTEST_SELECT), 32'h0);
        check("rst_runbist_sel", 32'(tap.RUNBIST_SELECT), 32'h0);
        check("rst_bsr", 32'(tap.BSR), 32'h0);
        check("rst_tdo", 32'(tap.TDO), 32'h0);
        check("rst_tdo_en", 32'(tap.TDO_EN), 32'h0);
        TRST = 1'b1;

        // IDCODE read straight after reset
        step(1'b0, 1'b0, d);
        dr_scan(32, {$urandom, $urandom}, dout);
        check("idcode_stream", dout[31:0], IDCODE_VAL);

        // GETTEST load: vector visible before Update-DR, single UPDATEDR pulse
        load_ir(4'h2, cap);
        check("ir_capture", 32'(cap), 32'h5);
        din = 64'h2A6;
        step(1'b1, 1'b0, d);
        step(1'b0, 1'b0, d);
        step(1'b0, 1'b0, d);
        for (int i = 0; i < 10; i++) step(i == 9, din[i], d);
        check("bsr_before_upd", 32'(tap.BSR), 32'h2A6);
        step(1'b1, 1'b0, d);
        check("updatedr_pulse", 32'(tap.UPDATEDR), 32'h1);
        check("gettest_sel_on", 32'(tap.GETTEST_SELECT), 32'h1);
        check("bsr_at_upd", 32'(tap.BSR), 32'h2A6);
        step(1'b0, 1'b0, d);
        check("updatedr_one_cycle", 32'(tap.UPDATEDR), 32'h0);

        // RUNBIST selects, then STATUS readback
        load_ir(4'h3, cap);
        check("runbist_sel_on", 32'(tap.RUNBIST_SELECT), 32'h1);
        check("gettest_sel_off", 32'(tap.GETTEST_SELECT), 32'h0);
        check("bsr_kept", 32'(tap.BSR), 32'h2A6);
        tap.BIST_STATUS = 16'hA5F0;
        load_ir(4'h4, cap);
        dr_scan(16, {$urandom, $urandom}, dout);
        check("status_stream", 32'(dout[15:0]), 32'hA5F0);

        // Unknown opcode behaves as BYPASS: 0 first, then TDI delayed by one
        load_ir(4'h7, cap);
        check("ir_capture_2", 32'(cap), 32'h5);
        din = {$urandom, $urandom};
        dr_scan(20, din, dout);
        check("bypass_first", 32'(dout[0]), 32'h0);
        check("bypass_delay", 32'(dout[19:1]), 32'(din[18:0]));

        // TMS 0,1,0,0 from Test-Logic-Reset lands in Shift-DR
        go_tlr();
        step(1'b0, 1'b0, d);
        step(1'b1, 1'b0, d);
        step(1'b0, 1'b0, d);
        step(1'b0, 1'b0, d);
        check("path_to_shdr", 32'(tap.TAP_STATE), 32'h2);

        // Five TMS=1 from every state reach Test-Logic-Reset
        for (int target = 0; target < 16; target++) begin
            go_tlr();
            reached = (m_state == 4'(target));
            for (int k = 0; k < 300 && !reached; k++) begin
                step(1'($urandom), 1'($urandom), d);
                reached = (m_state == 4'(target));
            end
            check("reach_state", 32'(tap.TAP_STATE), 32'(target));
            go_tlr();
            check("five_ones_tlr", 32'(tap.TAP_STATE), 32'hF);
        end

        // TRST in the middle of a GETTEST shift
        goto_rti();
        load_ir(4'h2, cap);
        step(1'b1, 1'b0, d);
        step(1'b0, 1'b0, d);
        step(1'b0, 1'b0, d);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, d);
        trst_pulse("trst_mid_shift");
        step(1'b0, 1'b0, d);

        // Randomized traffic
        ir_pick = '{4'h1, 4'h2, 4'h3, 4'h4, 4'hF, 4'h0};
        for (int t = 0; t < 120; t++) begin
            case ($urandom_range(0, 6))
                0: begin
                    ir_pick[5] = 4'($urandom);
                    load_ir(ir_pick[$urandom_range(0, 5)], cap);
                    check("rand_ir_capture", 32'(cap), 32'h5);
                end
                1, 2: dr_scan($urandom_range(1, 40), {$urandom, $urandom}, dout);
                3: begin
                    for (int k = 0; k < 25; k++) step(1'($urandom), 1'($urandom), d);
                    goto_rti();
                end
                4: tap.BIST_STATUS = 16'($urandom);
                5: dr_scan_paused();
                default: begin
                    if ($urandom_range(0, 3) == 0) begin
                        trst_pulse("rand_trst");
                        step(1'b0, 1'b0, d);
                    end else begin
                        dr_scan($urandom_range(1, 12), {$urandom, $urandom}, dout);
                    end
                end
            endcase
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
